// File: rtl/aeg_dispatch_ctrl.sv
// aeg_dispatch_ctrl: AEG register file plus a one-at-a-time instruction sequencer between dispatch and the core.
// Optional busy-cycle / instruction counters at CSR 0x0001/0x0002 when AEG_DISPATCH_PERF_CNT_EN is defined.
module aeg_dispatch_ctrl #(
    parameter int unsigned NUM_AEG  = 32,
    parameter int unsigned NUM_INST = 2,
    parameter int unsigned IDX_W    = 10
) (
    input  logic                    clk,
    input  logic                    i_reset_n,
    input  logic                    disp_inst_vld,
    input  logic [4:0]              disp_inst,
    input  logic [17:0]             disp_aeg_idx,
    input  logic                    disp_aeg_rd,
    input  logic                    disp_aeg_wr,
    input  logic [63:0]             disp_aeg_wr_data,
    output logic [17:0]             disp_aeg_cnt,
    output logic [15:0]             disp_exception,
    output logic                    disp_idle,
    output logic                    disp_rtn_data_vld,
    output logic [63:0]             disp_rtn_data,
    output logic                    disp_stall,
    output logic                    core_start,
    output logic [4:0]              core_inst,
    input  logic                    core_done,
    output logic [NUM_AEG*64-1:0]   core_aeg,
    input  logic                    core_aeg_wr_vld,
    input  logic [IDX_W-1:0]        core_aeg_wr_idx,
    input  logic [63:0]             core_aeg_wr_data,
    input  logic                    csr_rd_vld,
    input  logic [15:0]             csr_address,
    output logic                    csr_rd_ack,
    output logic [63:0]             csr_rd_data
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned INST_W = 5;
    localparam int unsigned CNT_W  = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [INST_W-1:0]   core_inst_q, core_inst_d;
    logic                core_start_q, core_start_d;
    logic                stall_q, stall_d;
    logic                idle_q, idle_d;
    logic [1:0]          exc_q, exc_d;
    logic                rtn_vld_q, rtn_vld_d;
    logic [DATA_W-1:0]   rtn_data_q, rtn_data_d;
    logic                csr_ack_q, csr_ack_d;
    logic [DATA_W-1:0]   csr_data_q, csr_data_d;
    logic [DATA_W-1:0]   aeg_q [NUM_AEG];
    logic [DATA_W-1:0]   aeg_d [NUM_AEG];
    logic                disp_in_rng;
    logic                inst_impl;

    assign disp_in_rng = 32'(disp_aeg_idx) < NUM_AEG;
    assign inst_impl   = 32'(disp_inst) < NUM_INST;

    // Sequencer: a new instruction is only accepted from IDLE.
    always_comb begin
        state_d     = state_q;
        core_inst_d = core_inst_q;
        exc_d       = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (disp_inst_vld) begin
                    if (inst_impl) begin
                        state_d     = ST_START;
                        core_inst_d = disp_inst;
                    end else begin
                        exc_d[0] = 1'b1;
                    end
                end
            end
            ST_START: state_d = core_done ? ST_IDLE : ST_BUSY;
            ST_BUSY:  if (core_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        exc_d[1]     = (disp_aeg_rd || disp_aeg_wr) && !disp_in_rng;
        core_start_d = (state_d == ST_START);
        stall_d      = (state_d != ST_IDLE);
        idle_d       = (state_d == ST_IDLE);
        rtn_vld_d    = disp_aeg_rd;
    end

    // Register file: reads see pre-write contents; core write-back overrides dispatch on the same index.
    always_comb begin
        aeg_d      = aeg_q;
        rtn_data_d = '0;
        for (int unsigned i = 0; i < NUM_AEG; i++) begin
            if (disp_aeg_rd && 32'(disp_aeg_idx) == i) rtn_data_d = aeg_q[i];
            if (disp_aeg_wr && 32'(disp_aeg_idx) == i) aeg_d[i] = disp_aeg_wr_data;
            if (core_aeg_wr_vld && 32'(core_aeg_wr_idx) == i) aeg_d[i] = core_aeg_wr_data;
        end
    end

`ifdef AEG_DISPATCH_PERF_CNT_EN
    logic [DATA_W-1:0] busy_cyc_q, busy_cyc_d;
    logic [DATA_W-1:0] inst_cnt_q, inst_cnt_d;

    always_comb begin
        busy_cyc_d = busy_cyc_q;
        inst_cnt_d = inst_cnt_q;
        if (state_q != ST_IDLE) busy_cyc_d = busy_cyc_q + 64'd1;
        if (state_q == ST_IDLE && state_d == ST_START) inst_cnt_d = inst_cnt_q + 64'd1;
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_cyc_q <= '0;
            inst_cnt_q <= '0;
        end else begin
            busy_cyc_q <= busy_cyc_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end
`endif

    always_comb begin
        csr_ack_d  = csr_rd_vld;
        csr_data_d = '0;
        if (csr_rd_vld) begin
            case (csr_address)
                16'h0000: csr_data_d = {60'b0, state_q, stall_q, idle_q};
`ifdef AEG_DISPATCH_PERF_CNT_EN
                16'h0001: csr_data_d = busy_cyc_q;
                16'h0002: csr_data_d = inst_cnt_q;
`endif
                default:  csr_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            core_inst_q  <= '0;
            core_start_q <= 1'b0;
            stall_q      <= 1'b0;
            idle_q       <= 1'b1;
            exc_q        <= 2'b00;
            rtn_vld_q    <= 1'b0;
            rtn_data_q   <= '0;
            csr_ack_q    <= 1'b0;
            csr_data_q   <= '0;
            for (int unsigned i = 0; i < NUM_AEG; i++) aeg_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            core_inst_q  <= core_inst_d;
            core_start_q <= core_start_d;
            stall_q      <= stall_d;
            idle_q       <= idle_d;
            exc_q        <= exc_d;
            rtn_vld_q    <= rtn_vld_d;
            rtn_data_q   <= rtn_data_d;
            csr_ack_q    <= csr_ack_d;
            csr_data_q   <= csr_data_d;
            for (int unsigned i = 0; i < NUM_AEG; i++) aeg_q[i] <= aeg_d[i];
        end
    end

    for (genvar g = 0; g < NUM_AEG; g++) begin : g_flat
        assign core_aeg[64*g +: 64] = aeg_q[g];
    end

    assign disp_aeg_cnt      = CNT_W'(NUM_AEG);
    assign disp_exception    = {14'b0, exc_q};
    assign disp_idle         = idle_q;
    assign disp_stall        = stall_q;
    assign disp_rtn_data_vld = rtn_vld_q;
    assign disp_rtn_data     = rtn_data_q;
    assign core_start        = core_start_q;
    assign core_inst         = core_inst_q;
    assign csr_rd_ack        = csr_ack_q;
    assign csr_rd_data       = csr_data_q;

endmodule

// File: tb/tb_aeg_dispatch_ctrl.sv
// Self-checking bench for aeg_dispatch_ctrl: randomized AEG traffic against an array model, plus sequencer/CSR/reset scenarios.
module tb_aeg_dispatch_ctrl;

    localparam int NA = 32;
    localparam int NI = 2;

    logic               clk;
    logic               i_reset_n;
    logic               disp_inst_vld;
    logic [4:0]         disp_inst;
    logic [17:0]        disp_aeg_idx;
    logic               disp_aeg_rd;
    logic               disp_aeg_wr;
    logic [63:0]        disp_aeg_wr_data;
    logic [17:0]        disp_aeg_cnt;
    logic [15:0]        disp_exception;
    logic               disp_idle;
    logic               disp_rtn_data_vld;
    logic [63:0]        disp_rtn_data;
    logic               disp_stall;
    logic               core_start;
    logic [4:0]         core_inst;
    logic               core_done;
    logic [NA*64-1:0]   core_aeg;
    logic               core_aeg_wr_vld;
    logic [9:0]         core_aeg_wr_idx;
    logic [63:0]        core_aeg_wr_data;
    logic               csr_rd_vld;
    logic [15:0]        csr_address;
    logic               csr_rd_ack;
    logic [63:0]        csr_rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] mdl [NA];
    longint tot_busy = 0;
    longint tot_inst = 0;

    aeg_dispatch_ctrl #(.NUM_AEG(NA), .NUM_INST(NI), .IDX_W(10)) dut (
        .clk(clk), .i_reset_n(i_reset_n),
        .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
        .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd), .disp_aeg_wr(disp_aeg_wr),
        .disp_aeg_wr_data(disp_aeg_wr_data), .disp_aeg_cnt(disp_aeg_cnt),
        .disp_exception(disp_exception), .disp_idle(disp_idle),
        .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
        .disp_stall(disp_stall), .core_start(core_start), .core_inst(core_inst),
        .core_done(core_done), .core_aeg(core_aeg), .core_aeg_wr_vld(core_aeg_wr_vld),
        .core_aeg_wr_idx(core_aeg_wr_idx), .core_aeg_wr_data(core_aeg_wr_data),
        .csr_rd_vld(csr_rd_vld), .csr_address(csr_address),
        .csr_rd_ack(csr_rd_ack), .csr_rd_data(csr_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NA*64-1:0] model_flat();
        logic [NA*64-1:0] f;
        for (int i = 0; i < NA; i++) f[64*i +: 64] = mdl[i];
        return f;
    endfunction

    task automatic test_reset();
        i_reset_n = 1'b0;
        disp_inst_vld = 0; disp_inst = '0; disp_aeg_idx = '0; disp_aeg_rd = 0; disp_aeg_wr = 0;
        disp_aeg_wr_data = '0; core_done = 0; core_aeg_wr_vld = 0; core_aeg_wr_idx = '0;
        core_aeg_wr_data = '0; csr_rd_vld = 0; csr_address = '0;
        for (int i = 0; i < NA; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (disp_idle !== 1'b1 || disp_stall !== 1'b0) begin n_fail++; $display("FAIL reset_idle_stall: idle=%b stall=%b want 1/0", disp_idle, disp_stall); end
        n_tests++; if (core_start !== 1'b0 || core_inst !== 5'd0) begin n_fail++; $display("FAIL reset_core: start=%b inst=%0d want 0/0", core_start, core_inst); end
        n_tests++; if (disp_exception !== 16'h0 || disp_rtn_data_vld !== 1'b0 || disp_rtn_data !== 64'h0) begin n_fail++; $display("FAIL reset_disp: exc=%h vld=%b data=%h want 0", disp_exception, disp_rtn_data_vld, disp_rtn_data); end
        n_tests++; if (csr_rd_ack !== 1'b0 || csr_rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_csr: ack=%b data=%h want 0", csr_rd_ack, csr_rd_data); end
        n_tests++; if (core_aeg !== model_flat()) begin n_fail++; $display("FAIL reset_aeg: core_aeg not all zero"); end
        n_tests++; if (disp_aeg_cnt !== 18'(NA)) begin n_fail++; $display("FAIL aeg_cnt: got %0d want %0d", disp_aeg_cnt, NA); end
        @(negedge clk);
        i_reset_n = 1'b1;
        step();
    endtask

    // Randomized dispatch/core AEG traffic; first iterations are directed boundary cases.
    task automatic test_aeg_rw();
        logic        rd, wr, cw;
        int          idx, cidx;
        logic [63:0] wd, cd, exp_d;
        logic [15:0] exp_exc;
        for (int it = 0; it < 80; it++) begin
            rd = ($urandom_range(0, 2) == 0); wr = ($urandom_range(0, 2) == 0); cw = ($urandom_range(0, 3) == 0);
            idx = $urandom_range(0, 39); cidx = $urandom_range(0, 39);
            wd = {$urandom, $urandom}; cd = {$urandom, $urandom};
            if (it < 5) begin rd = 0; wr = 0; cw = 0; end
            if (it == 0) begin wr = 1; idx = 3; wd = 64'hDEADBEEF_00000001; end
            if (it == 1) begin rd = 1; idx = 3; end
            if (it == 2) begin wr = 1; idx = 32; end
            if (it == 4) begin rd = 1; idx = 40; end
            disp_aeg_rd = rd; disp_aeg_wr = wr; disp_aeg_idx = 18'(idx); disp_aeg_wr_data = wd;
            core_aeg_wr_vld = cw; core_aeg_wr_idx = 10'(cidx); core_aeg_wr_data = cd;
            exp_d = (idx < NA) ? mdl[idx] : 64'h0;
            exp_exc = ((rd || wr) && idx >= NA) ? 16'h0002 : 16'h0000;
            if (wr && idx < NA) mdl[idx] = wd;
            if (cw && cidx < NA) mdl[cidx] = cd;
            step();
            n_tests++; if (disp_rtn_data_vld !== rd) begin n_fail++; $display("FAIL rd_vld it=%0d: got %b want %b", it, disp_rtn_data_vld, rd); end
            if (rd) begin
                n_tests++; if (disp_rtn_data !== exp_d) begin n_fail++; $display("FAIL rd_data it=%0d idx=%0d: got %h want %h", it, idx, disp_rtn_data, exp_d); end
            end
            n_tests++; if (disp_exception !== exp_exc) begin n_fail++; $display("FAIL aeg_exc it=%0d: got %h want %h", it, disp_exception, exp_exc); end
            n_tests++; if (core_aeg !== model_flat()) begin n_fail++; $display("FAIL aeg_contents it=%0d", it); end
        end
        disp_aeg_rd = 0; disp_aeg_wr = 0; core_aeg_wr_vld = 0;
    endtask

    task automatic test_same_cycle();
        disp_aeg_wr = 1; disp_aeg_idx = 18'd5; disp_aeg_wr_data = 64'hBB;
        core_aeg_wr_vld = 1; core_aeg_wr_idx = 10'd5; core_aeg_wr_data = 64'hAA;
        mdl[5] = 64'hAA;
        step();
        n_tests++; if (core_aeg[383:320] !== 64'hAA) begin n_fail++; $display("FAIL core_wins: got %h want aa", core_aeg[383:320]); end
        disp_aeg_idx = 18'd6; disp_aeg_wr_data = 64'h66;
        core_aeg_wr_idx = 10'd7; core_aeg_wr_data = 64'h77;
        mdl[6] = 64'h66; mdl[7] = 64'h77;
        step();
        disp_aeg_wr = 0; core_aeg_wr_vld = 0;
        n_tests++; if (core_aeg !== model_flat()) begin n_fail++; $display("FAIL both_land: aeg6=%h aeg7=%h want 66/77", core_aeg[447:384], core_aeg[511:448]); end
    endtask

    task automatic test_dispatch();
        logic [4:0] code;
        int d, c, starts, stall_cyc, bad_inst;
        for (int n = 0; n < 8; n++) begin
            code = 5'($urandom_range(0, NI - 1));
            d = $urandom_range(0, 6);
            if (n == 0) begin code = 5'd1; d = 5; end
            if (n == 1) d = 0;
            disp_inst_vld = 1; disp_inst = code;
            step();
            disp_inst_vld = 0;
            starts = 0; stall_cyc = 0; bad_inst = 0; c = 0;
            while (disp_stall === 1'b1 && c < 20) begin
                if (core_start === 1'b1) starts++;
                if (core_inst !== code || disp_idle !== 1'b0) bad_inst++;
                stall_cyc++;
                core_done = (c == d);
                if (c == 1) begin disp_inst_vld = 1; disp_inst = 5'($urandom_range(0, 31)); end
                step();
                core_done = 0; disp_inst_vld = 0;
                c++;
            end
            n_tests++; if (stall_cyc != d + 1) begin n_fail++; $display("FAIL stall_len n=%0d: got %0d want %0d", n, stall_cyc, d + 1); end
            n_tests++; if (starts != 1) begin n_fail++; $display("FAIL start_pulses n=%0d: got %0d want 1", n, starts); end
            n_tests++; if (bad_inst != 0) begin n_fail++; $display("FAIL core_inst_hold n=%0d: %0d bad cycles want 0", n, bad_inst); end
            n_tests++; if (disp_idle !== 1'b1 || core_start !== 1'b0 || disp_exception !== 16'h0) begin n_fail++; $display("FAIL after_done n=%0d: idle=%b start=%b exc=%h", n, disp_idle, core_start, disp_exception); end
            tot_busy += d + 1; tot_inst++;
            step();
            n_tests++; if (disp_idle !== 1'b1 || core_start !== 1'b0) begin n_fail++; $display("FAIL stalled_inst_ignored n=%0d: idle=%b start=%b", n, disp_idle, core_start); end
        end
        // unimplemented instruction, ORed with an out-of-range AEG write
        disp_inst_vld = 1; disp_inst = 5'd7; disp_aeg_wr = 1; disp_aeg_idx = 18'd100;
        step();
        disp_inst_vld = 0; disp_aeg_wr = 0;
        n_tests++; if (disp_exception !== 16'h0003 || disp_idle !== 1'b1 || core_start !== 1'b0) begin n_fail++; $display("FAIL bad_inst: exc=%h idle=%b start=%b want 0003/1/0", disp_exception, disp_idle, core_start); end
        disp_inst_vld = 1; disp_inst = 5'($urandom_range(NI, 31));
        step();
        disp_inst_vld = 0;
        n_tests++; if (disp_exception !== 16'h0001) begin n_fail++; $display("FAIL bad_inst_rand: exc=%h want 0001", disp_exception); end
        core_done = 1;
        step();
        core_done = 0;
        n_tests++; if (disp_exception !== 16'h0 || disp_idle !== 1'b1 || core_start !== 1'b0) begin n_fail++; $display("FAIL done_in_idle: exc=%h idle=%b start=%b", disp_exception, disp_idle, core_start); end
    endtask

    task automatic test_csr();
        logic [63:0] exp1, exp2;
        csr_rd_vld = 1; csr_address = 16'h0000;
        step();
        n_tests++; if (csr_rd_ack !== 1'b1 || csr_rd_data !== 64'h1) begin n_fail++; $display("FAIL csr_idle: ack=%b data=%h want 1/1", csr_rd_ack, csr_rd_data); end
        csr_rd_vld = 0;
        disp_inst_vld = 1; disp_inst = 5'd0;
        step();
        n_tests++; if (csr_rd_ack !== 1'b0) begin n_fail++; $display("FAIL csr_ack_pulse: ack=%b want 0", csr_rd_ack); end
        disp_inst_vld = 0;
        csr_rd_vld = 1;
        step();
        n_tests++; if (csr_rd_data !== 64'h6) begin n_fail++; $display("FAIL csr_start: data=%h want 6", csr_rd_data); end
        step();
        n_tests++; if (csr_rd_data !== 64'hA) begin n_fail++; $display("FAIL csr_busy: data=%h want a", csr_rd_data); end
        csr_rd_vld = 0; core_done = 1;
        step();
        core_done = 0;
        tot_busy += 3; tot_inst++;
        n_tests++; if (disp_idle !== 1'b1) begin n_fail++; $display("FAIL csr_inst_end: idle=%b want 1", disp_idle); end
`ifdef AEG_DISPATCH_PERF_CNT_EN
        exp1 = 64'(tot_busy); exp2 = 64'(tot_inst);
`else
        exp1 = 64'h0; exp2 = 64'h0;
`endif
        csr_rd_vld = 1; csr_address = 16'h0001;
        step();
        n_tests++; if (csr_rd_ack !== 1'b1 || csr_rd_data !== exp1) begin n_fail++; $display("FAIL csr_busy_cyc: ack=%b data=%0d want 1/%0d", csr_rd_ack, csr_rd_data, exp1); end
        csr_address = 16'h0002;
        step();
        n_tests++; if (csr_rd_ack !== 1'b1 || csr_rd_data !== exp2) begin n_fail++; $display("FAIL csr_inst_cnt: ack=%b data=%0d want 1/%0d", csr_rd_ack, csr_rd_data, exp2); end
        csr_address = 16'(16'h0003 + $urandom_range(0, 16'hFFF0));
        step();
        csr_rd_vld = 0;
        n_tests++; if (csr_rd_ack !== 1'b1 || csr_rd_data !== 64'h0) begin n_fail++; $display("FAIL csr_unmapped: ack=%b data=%h want 1/0", csr_rd_ack, csr_rd_data); end
    endtask

    task automatic test_reset_mid();
        disp_aeg_wr = 1; disp_aeg_idx = 18'd0; disp_aeg_wr_data = 64'h1234_5678_9ABC_DEF0;
        disp_inst_vld = 1; disp_inst = 5'd1;
        step();
        disp_aeg_wr = 0; disp_inst_vld = 0;
        step();
        n_tests++; if (disp_stall !== 1'b1 || core_aeg[63:0] !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL pre_reset_busy: stall=%b aeg0=%h", disp_stall, core_aeg[63:0]); end
        #2;
        i_reset_n = 1'b0;
        #1;
        for (int i = 0; i < NA; i++) mdl[i] = '0;
        n_tests++; if (disp_stall !== 1'b0 || disp_idle !== 1'b1 || core_start !== 1'b0) begin n_fail++; $display("FAIL async_reset: stall=%b idle=%b start=%b want 0/1/0", disp_stall, disp_idle, core_start); end
        n_tests++; if (core_aeg !== model_flat()) begin n_fail++; $display("FAIL async_reset_aeg: aeg not cleared"); end
        @(negedge clk);
        i_reset_n = 1'b1;
        core_done = 1;
        step();
        core_done = 0;
        n_tests++; if (disp_idle !== 1'b1 || core_start !== 1'b0 || disp_stall !== 1'b0) begin n_fail++; $display("FAIL late_done: idle=%b start=%b stall=%b", disp_idle, core_start, disp_stall); end
        for (int i = 0; i < 4; i++) begin
            disp_aeg_rd = 1; disp_aeg_idx = 18'(i);
            step();
            n_tests++; if (disp_rtn_data_vld !== 1'b1 || disp_rtn_data !== 64'h0) begin n_fail++; $display("FAIL post_reset_rd%0d: vld=%b data=%h want 1/0", i, disp_rtn_data_vld, disp_rtn_data); end
        end
        disp_aeg_rd = 0;
    endtask

    initial begin
        test_reset();
        test_aeg_rw();
        test_same_cycle();
        test_dispatch();
        test_csr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
